sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//  Shares one single-read/single-write word SRAM (16-bit words, byte addresses, word = addr>>1)
//  between two read requesters (e.g. weight fetch, state fetch) and one writer in the LSTM datapath.
//  Round-robins the read port and defers reads that would hit the SRAM RAW window, which returns X.
//  Delivers each granted read's data to its requester with fixed latency.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width, all address ports
//  DATA_WIDTH  16  SRAM word width
//  CNT_WIDTH   16  width of saturating hazard-stall counter
// PORTS
//  clock              in   1           single clock, all state on posedge
//  reset_b            in   1           asynchronous, active-low reset
//  rd0_req            in   1           requester 0 read request; hold, rd0_addr stable, until rd0_gnt
//  rd0_addr           in   ADDR_WIDTH  requester 0 byte address
//  rd0_gnt            out  1           combinational grant, same cycle as accepted request
//  rd0_rvalid         out  1           read data valid for requester 0 (registered)
//  rd0_rdata          out  DATA_WIDTH  read data, valid only when rd0_rvalid
//  rd1_req/rd1_addr/rd1_gnt/rd1_rvalid/rd1_rdata   as above, requester 1
//  wr_req             in   1           write request; always accepted the same cycle
//  wr_addr            in   ADDR_WIDTH  write byte address
//  wr_data            in   DATA_WIDTH  write data
//  sram_read_address  out  ADDR_WIDTH  to SRAM read_address
//  sram_read_enable   out  1           to SRAM read_enable
//  sram_read_data     in   DATA_WIDTH  from SRAM read_data
//  sram_write_address out  ADDR_WIDTH  to SRAM write_address
//  sram_write_data    out  DATA_WIDTH  to SRAM write_data
//  sram_write_enable  out  1           to SRAM write_enable
//  hazard_stalls      out  CNT_WIDTH   saturating count of cycles a request was held off by hazard
// BEHAVIOUR
//  Reset (reset_b=0): gnts, rvalids, sram enables 0; sram addresses, wr data, rdata, hazard_stalls 0;
//   rr pointer = requester 0; hazard regs cleared. Gnts and enables forced 0 while reset_b=0.
//  Write path: combinational pass-through; sram_write_enable = wr_req. Writes never stall.
//  Hazard regs: last_wr_word <= wr_addr>>1, last_wr_en <= wr_req, every cycle.
//  Hazard for request i: (addr_i>>1)==(wr_addr>>1) && wr_req   (same-cycle write)
//                      or (addr_i>>1)==last_wr_word && last_wr_en (write previous cycle).
//  Eligible_i = req_i && !hazard_i. Hazarded reads are retried next cycle, request still held.
//  Arbitration: both eligible -> grant requester at rr pointer; one eligible -> grant it.
//   On grant to i, pointer <= other requester. No grant -> pointer unchanged.
//  Grant cycle: sram_read_enable=1, sram_read_address=granted addr. Idle: enable 0, address holds
//   last driven value (never X), so SRAM X-check is never triggered by idle address.
//  Latency: rvalid_i registered 1 cycle after gnt_i; rdata_i = sram_read_data in that cycle.
//   Back-to-back grants give one response per cycle, in grant order; response carries owner tag.
//  hazard_stalls: +1 per cycle where any req_i is high and hazard_i blocks it (once per cycle),
//   saturates at all-ones.
//  Reset mid-operation: pending rvalid discarded; no response emitted for a grant issued in the
//   cycle reset asserts.
//  Starvation: continuous writes to the requested word may starve that reader; by design.
// TESTING
//  1 SRAM word 8 = 0x1234; rd0_req addr 0x10 -> rd0_gnt same cycle, next cycle rd0_rvalid=1 rdata 0x1234.
//  2 rd0_req addr 0x20 and rd1_req addr 0x40 held 4 cycles after reset -> grants 0,1,0,1; rvalids follow 1 cycle later.
//  3 Write 0x0A/0xBEEF cycle t; rd0_req addr 0x0B from t+1 -> no gnt t+1, gnt t+2, rvalid t+3 rdata 0xBEEF, hazard_stalls=1.
//  4 wr_req addr 0x30 with rd0_req addr 0x31 same cycle -> rd0 deferred; with rd0_addr 0x32 -> granted same cycle.
//  5 rd0 hazarded (matches prior write), rd1 clean, pointer at 0 -> rd1 granted; rd0 granted next cycle.
//  6 reset_b low the cycle after a gnt -> no rvalid, hazard_stalls 0, next dual request granted to requester 0.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// ============================================================================
// Module   : sram_access_arbiter
// Purpose  : Shares one 1R/1W word SRAM between two read requesters and one
//            writer. The read port is round-robin, reads that would hit the
//            SRAM read-after-write window are deferred, and each requester gets
//            its read data one cycle after it is granted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_b,

  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_gnt,
  output logic                  rd0_rvalid,
  output logic [DATA_WIDTH-1:0] rd0_rdata,

  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_gnt,
  output logic                  rd1_rvalid,
  output logic [DATA_WIDTH-1:0] rd1_rdata,

  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,

  output logic [ADDR_WIDTH-1:0] sram_read_address,
  output logic                  sram_read_enable,
  input  logic [DATA_WIDTH-1:0] sram_read_data,
  output logic [ADDR_WIDTH-1:0] sram_write_address,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  output logic                  sram_write_enable,

  output logic [CNT_WIDTH-1:0]  hazard_stalls
);

  // Round-robin priority: which requester wins when both are eligible.
  typedef enum logic {
    PRIO_RD0 = 1'b0,
    PRIO_RD1 = 1'b1
  } prio_t;

  prio_t                 r_prio;
  prio_t                 w_prio_next;

  logic [ADDR_WIDTH-1:0] w_rd0_word;
  logic [ADDR_WIDTH-1:0] w_rd1_word;
  logic [ADDR_WIDTH-1:0] w_wr_word;
  logic [ADDR_WIDTH-1:0] r_last_wr_word;
  logic                  r_last_wr_en;

  logic                  w_hazard0;
  logic                  w_hazard1;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_stall;

  logic [ADDR_WIDTH-1:0] r_rd_addr_hold;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [CNT_WIDTH-1:0]  r_stalls;

  assign w_rd0_word = rd0_addr >> 1;
  assign w_rd1_word = rd1_addr >> 1;
  assign w_wr_word  = wr_addr  >> 1;

  // A read of a word written this cycle or last cycle would return X.
  assign w_hazard0 = ((w_rd0_word == w_wr_word) && wr_req) ||
                     ((w_rd0_word == r_last_wr_word) && r_last_wr_en);
  assign w_hazard1 = ((w_rd1_word == w_wr_word) && wr_req) ||
                     ((w_rd1_word == r_last_wr_word) && r_last_wr_en);

  assign w_elig0 = rd0_req && !w_hazard0;
  assign w_elig1 = rd1_req && !w_hazard1;

  assign w_stall = (rd0_req && w_hazard0) || (rd1_req && w_hazard1);

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_prio_next = r_prio;
    if (reset_b) begin
      if (w_elig0 && w_elig1) begin
        w_gnt0 = (r_prio == PRIO_RD0);
        w_gnt1 = (r_prio == PRIO_RD1);
      end else begin
        w_gnt0 = w_elig0;
        w_gnt1 = w_elig1;
      end
      if (w_gnt0) begin
        w_prio_next = PRIO_RD1;
      end else if (w_gnt1) begin
        w_prio_next = PRIO_RD0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_prio <= PRIO_RD0;
    end else begin
      r_prio <= w_prio_next;
    end
  end

  assign rd0_gnt = w_gnt0;
  assign rd1_gnt = w_gnt1;

  // Idle cycles keep the last driven read address so the SRAM never sees X.
  always_comb begin
    sram_read_enable  = w_gnt0 || w_gnt1;
    sram_read_address = r_rd_addr_hold;
    if (w_gnt0) begin
      sram_read_address = rd0_addr;
    end else if (w_gnt1) begin
      sram_read_address = rd1_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_rd_addr_hold <= '0;
    end else if (sram_read_enable) begin
      r_rd_addr_hold <= sram_read_address;
    end
  end

  assign sram_write_enable  = reset_b && wr_req;
  assign sram_write_address = reset_b ? wr_addr : '0;
  assign sram_write_data    = reset_b ? wr_data : '0;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_last_wr_word <= '0;
      r_last_wr_en   <= 1'b0;
    end else begin
      r_last_wr_word <= w_wr_word;
      r_last_wr_en   <= wr_req;
    end
  end

  // The rvalid flag is the owner tag: exactly one is set per response cycle.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0;
      r_rvalid1 <= w_gnt1;
    end
  end

  assign rd0_rvalid = r_rvalid0;
  assign rd1_rvalid = r_rvalid1;
  assign rd0_rdata  = r_rvalid0 ? sram_read_data : '0;
  assign rd1_rdata  = r_rvalid1 ? sram_read_data : '0;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_stalls <= '0;
    end else if (w_stall && (r_stalls != {CNT_WIDTH{1'b1}})) begin
      r_stalls <= r_stalls + 1'b1;
    end
  end

  assign hazard_stalls = r_stalls;

endmodule

`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
// ============================================================================
// Module   : tb_sram_access_arbiter
// Purpose  : Scoreboard bench for sram_access_arbiter with an SRAM model that
//            returns X inside the read-after-write window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_access_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_b;
  logic          rd0_req, rd1_req, wr_req;
  logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid;
  logic [DW-1:0] rd0_rdata, rd1_rdata;
  logic [AW-1:0] sram_read_address, sram_write_address;
  logic          sram_read_enable, sram_write_enable;
  logic [DW-1:0] sram_read_data, sram_write_data;
  logic [CW-1:0] hazard_stalls;

  always #5 clock = ~clock;

  sram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_b(reset_b),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_rvalid(rd0_rvalid), .rd0_rdata(rd0_rdata),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_rvalid(rd1_rvalid), .rd1_rdata(rd1_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .sram_read_address(sram_read_address), .sram_read_enable(sram_read_enable),
    .sram_read_data(sram_read_data),
    .sram_write_address(sram_write_address), .sram_write_data(sram_write_data),
    .sram_write_enable(sram_write_enable),
    .hazard_stalls(hazard_stalls)
  );

  // SRAM: registered read, X when reading a word written this or last cycle.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    prev_word;
  logic          prev_we = 1'b0;
  always @(posedge clock) begin
    if (sram_read_enable) begin
      if ((sram_write_enable && sram_read_address[8:1] == sram_write_address[8:1]) ||
          (prev_we && sram_read_address[8:1] == prev_word))
        sram_read_data <= 'x;
      else
        sram_read_data <= mem[sram_read_address[8:1]];
    end
    if (sram_write_enable) mem[sram_write_address[8:1]] <= sram_write_data;
    prev_we   <= sram_write_enable;
    prev_word <= sram_write_address[8:1];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h expected %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  // Reference model state, expressed in terms of the arbitration rules.
  logic [DW-1:0] ref_mem [0:255];
  int            favored;
  int            prev_wr_word;
  bit            prev_wr_valid;
  int            stall_cnt;
  logic [AW-1:0] last_rd_addr;
  int            winner;

  function automatic bit blocked(input logic [AW-1:0] a);
    int word;
    word = int'(a / 2);
    return (wr_req && word == int'(wr_addr / 2)) || (prev_wr_valid && word == prev_wr_word);
  endfunction

  task automatic model_reset();
    favored       = 0;
    prev_wr_word  = 0;
    prev_wr_valid = 0;
    stall_cnt     = 0;
    last_rd_addr  = '0;
    winner        = -1;
  endtask

  task automatic model_cycle();
    bit b0, b1, ok0, ok1;
    logic [AW-1:0] exp_ra;
    b0  = rd0_req && blocked(rd0_addr);
    b1  = rd1_req && blocked(rd1_addr);
    ok0 = rd0_req && !b0;
    ok1 = rd1_req && !b1;
    if (ok0 && ok1) winner = favored;
    else if (ok0)   winner = 0;
    else if (ok1)   winner = 1;
    else            winner = -1;

    exp_ra = (winner == 0) ? rd0_addr : (winner == 1) ? rd1_addr : last_rd_addr;
    chk("rd0_gnt", rd0_gnt, winner == 0);
    chk("rd1_gnt", rd1_gnt, winner == 1);
    chk("rd_en", sram_read_enable, winner >= 0);
    chk("rd_addr", sram_read_address, exp_ra);
    chk("wr_en", sram_write_enable, wr_req);
    if (wr_req) begin
      chk("wr_addr", sram_write_address, wr_addr);
      chk("wr_data", sram_write_data, wr_data);
    end
    chk("stalls", hazard_stalls, stall_cnt);

    if (winner >= 0) begin
      sb.push_back('{owner: winner, data: ref_mem[exp_ra[8:1]], due: cyc + 1});
      favored      = 1 - winner;
      last_rd_addr = exp_ra;
    end
    if ((b0 || b1) && stall_cnt < SAT) stall_cnt++;
    if (wr_req) ref_mem[wr_addr[8:1]] = wr_data;
    prev_wr_word  = int'(wr_addr / 2);
    prev_wr_valid = wr_req;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit q0, input logic [AW-1:0] a0,
                      input bit q1, input logic [AW-1:0] a1,
                      input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd0_req = q0; rd0_addr = a0;
    rd1_req = q1; rd1_addr = a1;
    wr_req  = w;  wr_addr  = wa; wr_data = wd;
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, '0, '0);
  endtask

  // Requests and a write are driven during reset to show they are masked.
  task automatic do_reset();
    reset_b = 1'b0;
    rd0_req = 1; rd0_addr = 32'h10;
    rd1_req = 1; rd1_addr = 32'h20;
    wr_req  = 1; wr_addr  = 32'h30; wr_data = 16'hA5A5;
    model_reset();
    @(negedge clock);
    chk("rst_gnt0", rd0_gnt, 1'b0);
    chk("rst_gnt1", rd1_gnt, 1'b0);
    chk("rst_rvalid0", rd0_rvalid, 1'b0);
    chk("rst_rvalid1", rd1_rvalid, 1'b0);
    chk("rst_rdata0", rd0_rdata, '0);
    chk("rst_rdata1", rd1_rdata, '0);
    chk("rst_rd_en", sram_read_enable, 1'b0);
    chk("rst_rd_addr", sram_read_address, '0);
    chk("rst_wr_en", sram_write_enable, 1'b0);
    chk("rst_wr_addr", sram_write_address, '0);
    chk("rst_wr_data", sram_write_data, '0);
    chk("rst_stalls", hazard_stalls, '0);
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    @(posedge clock);
    #1;
    reset_b = 1'b1;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_b) begin
        sb.delete();
      end else begin
        if (rd0_rvalid && rd1_rvalid) chk("dual_rvalid", 32'd1, 32'd0);
        if (rd0_rvalid || rd1_rvalid) begin
          if (sb.size() == 0) begin
            chk("spurious_rvalid", {rd1_rvalid, rd0_rvalid}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_owner", rd1_rvalid ? 32'd1 : 32'd0, e.owner);
            chk("resp_data", rd0_rvalid ? rd0_rdata : rd1_rdata, e.data);
            chk("resp_cycle", cyc, e.due);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("missing_rvalid", 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    bit            hold0, hold1;
    logic [AW-1:0] ha0, ha1;
    reset_b = 1'b1;
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    #1;
    do_reset();

    // Preload words 0..39; word 8 (byte 0x10) holds 0x1234.
    for (int w = 0; w < 40; w++)
      step(0, '0, 0, '0, 1, AW'(w * 2), (w == 8) ? 16'h1234 : DW'($urandom));
    idle();

    // Single read of word 8.
    step(1, 32'h10, 0, '0, 0, '0, '0);
    idle();

    // Dual requests alternate 0,1,0,1 from a fresh reset.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h20, 1, 32'h40, 0, '0, '0);
    idle();

    // Read of a word written the previous cycle waits one cycle.
    step(0, '0, 0, '0, 1, 32'h0A, 16'hBEEF);
    step(1, 32'h0B, 0, '0, 0, '0, '0);
    step(1, 32'h0B, 0, '0, 0, '0, '0);
    idle();

    // Same-cycle write to the same word defers; to a different word does not.
    step(1, 32'h31, 0, '0, 1, 32'h30, 16'h0F0F);
    step(1, 32'h31, 0, '0, 0, '0, '0);
    step(1, 32'h31, 0, '0, 0, '0, '0);
    idle();
    step(1, 32'h32, 0, '0, 1, 32'h30, 16'h1111);
    idle();

    // rd0 blocked by the previous write, rd1 clean while rd0 is favored.
    do_reset();
    step(0, '0, 0, '0, 1, 32'h04, 16'hCAFE);
    step(1, 32'h05, 1, 32'h06, 0, '0, '0);
    step(1, 32'h05, 0, '0, 0, '0, '0);
    idle();

    // Reset the cycle after a grant drops the response and priority.
    step(1, 32'h10, 0, '0, 0, '0, '0);
    step(1, 32'h10, 0, '0, 0, '0, '0);
    do_reset();
    step(1, 32'h20, 1, 32'h40, 0, '0, '0);
    idle();

    // Continuous writes to the requested word saturate the stall counter.
    do_reset();
    for (int i = 0; i < SAT + 5; i++) step(1, 32'h08, 0, '0, 1, 32'h09, DW'($urandom));
    step(1, 32'h08, 0, '0, 0, '0, '0);
    step(0, '0, 0, '0, 0, '0, '0);
    idle();

    // Randomized traffic with requests held until granted.
    hold0 = 0; hold1 = 0; ha0 = '0; ha1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) begin
        do_reset();
        hold0 = 0; hold1 = 0;
      end
      if (!hold0 && $urandom_range(0, 2) != 0) begin hold0 = 1; ha0 = AW'($urandom_range(0, 15)); end
      if (!hold1 && $urandom_range(0, 2) != 0) begin hold1 = 1; ha1 = AW'($urandom_range(0, 15)); end
      step(hold0, ha0, hold1, ha1, $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, 15)), DW'($urandom));
      if (winner == 0) hold0 = 0;
      if (winner == 1) hold1 = 0;
    end
    idle();
    idle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
